// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction memory port, decode handshake and
// execute redirect. The master side is the fetch stage itself.
interface fetch_stage_if;
  logic        o_imem_ren;
  logic [31:0] o_imem_raddr;
  logic [31:0] i_imem_rdata;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_misaligned;

  modport master (
    output o_imem_ren, o_imem_raddr, o_valid, o_instr, o_pc, o_misaligned,
    input  i_imem_rdata, i_ready, i_redirect, i_redirect_pc
  );

  modport slave (
    input  o_imem_ren, o_imem_raddr, o_valid, o_instr, o_pc, o_misaligned,
    output i_imem_rdata, i_ready, i_redirect, i_redirect_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage: owns the PC, drives a one-cycle-latency
// instruction memory, and hands {instr, pc} to decode over valid/ready.
// A single hold slot parks the in-flight word when decode stalls, so no
// response is ever dropped; redirects from execute flush both slots.
module fetch_stage #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  fetch_stage_if.master bus
);

  typedef enum logic {FETCH, HALT} mode_t;

  mode_t       mode_q, mode_d;
  logic [31:0] pc_q, pc_d;
  logic        if_v_q, if_v_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        h_v_q, h_v_d;
  logic [31:0] h_pc_q, h_pc_d;
  logic [31:0] h_instr_q, h_instr_d;
  logic        mis_q, mis_d;

  logic valid;
  logic fire;
  logic issue;
  logic aligned;

  // State register: PC, in-flight slot, hold slot, mode and sticky flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q    <= FETCH;
      pc_q      <= RESET_ADDR;
      if_v_q    <= 1'b0;
      if_pc_q   <= '0;
      h_v_q     <= 1'b0;
      h_pc_q    <= '0;
      h_instr_q <= '0;
      mis_q     <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      pc_q      <= pc_d;
      if_v_q    <= if_v_d;
      if_pc_q   <= if_pc_d;
      h_v_q     <= h_v_d;
      h_pc_q    <= h_pc_d;
      h_instr_q <= h_instr_d;
      mis_q     <= mis_d;
    end
  end

  // Output mux, issue decision and next-state; redirect overrides everything.
  always_comb begin
    mode_d    = mode_q;
    pc_d      = pc_q;
    if_v_d    = if_v_q;
    if_pc_d   = if_pc_q;
    h_v_d     = h_v_q;
    h_pc_d    = h_pc_q;
    h_instr_d = h_instr_q;
    mis_d     = mis_q;

    aligned = (bus.i_redirect_pc[1:0] == 2'b00);
    valid   = !bus.i_redirect & (h_v_q | if_v_q);
    fire    = valid & bus.i_ready;
    issue   = (mode_q == FETCH) & !(valid & !bus.i_ready);

    bus.o_valid      = valid;
    bus.o_misaligned = mis_q;
    // rdata is gated by if_v so nothing stale leaks out after reset/flush
    bus.o_instr      = h_v_q ? h_instr_q : (if_v_q ? bus.i_imem_rdata : '0);
    bus.o_pc         = h_v_q ? h_pc_q : if_pc_q;
    bus.o_imem_raddr = bus.i_redirect ? bus.i_redirect_pc : pc_q;
    bus.o_imem_ren   = i_rst_n & (bus.i_redirect ? aligned : issue);

    if (bus.i_redirect) begin
      h_v_d = 1'b0;
      if (aligned) begin
        if_v_d  = 1'b1;
        if_pc_d = bus.i_redirect_pc;
        pc_d    = bus.i_redirect_pc + 32'd4;
        mode_d  = FETCH;
        mis_d   = 1'b0;
      end else begin
        if_v_d = 1'b0;
        mode_d = HALT;
        mis_d  = 1'b1;
      end
    end else begin
      if (issue) begin
        if_v_d  = 1'b1;
        if_pc_d = pc_q;
        pc_d    = pc_q + 32'd4;
      end else begin
        if_v_d = 1'b0;
      end
      if (if_v_q && !h_v_q && !fire) begin
        h_v_d     = 1'b1;
        h_instr_d = bus.i_imem_rdata;
        h_pc_d    = if_pc_q;
      end
      if (h_v_q && fire) begin
        h_v_d = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];

  fetch_stage_if bus_if();

  fetch_stage #(.RESET_ADDR(32'h0000_0100)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: one-cycle latency, data = address ^ KEY.
  always @(posedge clk) begin
    if (bus_if.o_imem_ren) bus_if.i_imem_rdata <= bus_if.o_imem_raddr ^ KEY;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = pc ^ KEY;
    exp_q.push_back(e);
  endtask

  // Drive one cycle's inputs just after the rising edge, then wait for the
  // falling edge so the caller can sample settled outputs.
  task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    bus_if.i_ready       = rdy;
    bus_if.i_redirect    = redir;
    bus_if.i_redirect_pc = rpc;
    @(negedge clk);
  endtask

  // Scoreboard monitor: every fire is compared against the queue head.
  always @(negedge clk) begin
    if (rst_n && bus_if.o_valid && bus_if.i_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_fire actual_pc=%h actual_instr=%h required=none",
                 bus_if.o_pc, bus_if.o_instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus_if.o_pc !== e.pc || bus_if.o_instr !== e.instr) begin
          errors++;
          $display("FAIL fire actual_pc=%h actual_instr=%h required_pc=%h required_instr=%h",
                   bus_if.o_pc, bus_if.o_instr, e.pc, e.instr);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus_if.i_ready       = 1'b1;
    bus_if.i_redirect    = 1'b0;
    bus_if.i_redirect_pc = '0;
    bus_if.i_imem_rdata  = 32'hDEAD_BEEF;

    // Reset state
    step(1'b1, 1'b0, 32'h0);
    chk("rst_valid", {31'b0, bus_if.o_valid}, 32'd0);
    chk("rst_ren", {31'b0, bus_if.o_imem_ren}, 32'd0);
    chk("rst_instr", bus_if.o_instr, 32'h0);
    chk("rst_pc", bus_if.o_pc, 32'h0);
    chk("rst_mis", {31'b0, bus_if.o_misaligned}, 32'd0);

    push(32'h100); push(32'h104); push(32'h108); push(32'h10C);

    // c0: release; first fetch at RESET_ADDR in this same cycle
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("c0_ren", {31'b0, bus_if.o_imem_ren}, 32'd1);
    chk("c0_raddr", bus_if.o_imem_raddr, 32'h100);
    chk("c0_valid", {31'b0, bus_if.o_valid}, 32'd0);
    // c1: 0x100 out, 0x104 read
    step(1'b1, 1'b0, 32'h0);
    chk("c1_valid", {31'b0, bus_if.o_valid}, 32'd1);
    chk("c1_raddr", bus_if.o_imem_raddr, 32'h104);
    // c2..c4: stall with 0x104 on output
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0);
      chk("stall_pc", bus_if.o_pc, 32'h104);
      chk("stall_instr", bus_if.o_instr, 32'h104 ^ KEY);
      chk("stall_ren", {31'b0, bus_if.o_imem_ren}, 32'd0);
    end
    // c5: release, held word fires and 0x108 issues together
    step(1'b1, 1'b0, 32'h0);
    chk("rel_ren", {31'b0, bus_if.o_imem_ren}, 32'd1);
    chk("rel_raddr", bus_if.o_imem_raddr, 32'h108);
    step(1'b1, 1'b0, 32'h0);  // c6: 0x108
    step(1'b1, 1'b0, 32'h0);  // c7: 0x10C
    step(1'b0, 1'b0, 32'h0);  // c8: 0x110 in flight, not taken
    step(1'b0, 1'b0, 32'h0);  // c9: 0x110 held
    chk("held_pc", bus_if.o_pc, 32'h110);

    // c10: redirect to 0x2000 flushes the held word
    push(32'h2000); push(32'h2004);
    step(1'b1, 1'b1, 32'h0000_2000);
    chk("redir_valid", {31'b0, bus_if.o_valid}, 32'd0);
    chk("redir_raddr", bus_if.o_imem_raddr, 32'h2000);
    chk("redir_ren", {31'b0, bus_if.o_imem_ren}, 32'd1);
    step(1'b1, 1'b0, 32'h0);  // c11: 0x2000
    chk("redir_pc1", bus_if.o_pc, 32'h2000);
    step(1'b1, 1'b0, 32'h0);  // c12: 0x2004

    // c13: misaligned redirect flushes in-flight 0x2008 and halts
    step(1'b1, 1'b1, 32'h0000_2002);
    chk("mis_ren0", {31'b0, bus_if.o_imem_ren}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 32'h0);
      chk("halt_mis", {31'b0, bus_if.o_misaligned}, 32'd1);
      chk("halt_ren", {31'b0, bus_if.o_imem_ren}, 32'd0);
      chk("halt_valid", {31'b0, bus_if.o_valid}, 32'd0);
    end
    // c16: aligned redirect resumes from HALT
    push(32'h3000); push(32'h3004);
    step(1'b1, 1'b1, 32'h0000_3000);
    chk("resume_ren", {31'b0, bus_if.o_imem_ren}, 32'd1);
    chk("resume_raddr", bus_if.o_imem_raddr, 32'h3000);
    step(1'b1, 1'b0, 32'h0);  // c17: 0x3000
    chk("resume_mis", {31'b0, bus_if.o_misaligned}, 32'd0);
    step(1'b1, 1'b0, 32'h0);  // c18: 0x3004

    // c19: redirect to top of address space, then wrap
    push(32'hFFFF_FFFC); push(32'h0); push(32'h4);
    step(1'b1, 1'b1, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'h0);  // c20: FFFFFFFC
    step(1'b1, 1'b0, 32'h0);  // c21: 0x0
    chk("wrap_pc", bus_if.o_pc, 32'h0);
    step(1'b1, 1'b0, 32'h0);  // c22: 0x4
    step(1'b0, 1'b0, 32'h0);  // c23: 0x8 in flight
    step(1'b0, 1'b0, 32'h0);  // c24: 0x8 held
    chk("pre_rst_valid", {31'b0, bus_if.o_valid}, 32'd1);
    chk("pre_rst_pc", bus_if.o_pc, 32'h8);

    // Asynchronous reset mid-stall
    #2; rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, bus_if.o_valid}, 32'd0);
    chk("arst_ren", {31'b0, bus_if.o_imem_ren}, 32'd0);
    step(1'b1, 1'b0, 32'h0);
    push(32'h100);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_raddr", bus_if.o_imem_raddr, 32'h100);
    chk("rst2_ren", {31'b0, bus_if.o_imem_ren}, 32'd1);
    step(1'b1, 1'b0, 32'h0);  // 0x100 fires
    step(1'b1, 1'b1, 32'h0000_0001);  // halt to stop the stream
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
